match_collector: RTL and testbench
==================================

MATCH_COLLECTOR -- requirements
Module: match_collector

Interface
REQ-001 Parameter NPE, default 8, number of PE match lanes (maximum pattern length).
REQ-002 Parameter POS_W, default 16, width of the string-position counter and of reported positions.
REQ-003 Parameter CNT_W, default 16, width of the total-match counter.
REQ-004 Parameter FIFO_DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-005 clk  input  1  clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse; begins a new search, latches plen.
REQ-008 plen  input  $clog2(NPE+1)  active pattern length, sampled only on start.
REQ-009 in_valid  input  1  match_vec valid for the next string window.
REQ-010 in_last  input  1  qualifies in_valid; marks the final window of the string.
REQ-011 match_vec  input  NPE  per-PE compare bits; bit i = pattern char i equals string char pos+i.
REQ-012 out_valid  output  1  out_pos holds a reported match position.
REQ-013 out_ready  input  1  consumer accepts out_pos when out_valid && out_ready.
REQ-014 out_pos  output  POS_W  window start position of a full match.
REQ-015 match_count  output  CNT_W  number of full matches detected in the current search.
REQ-016 overflow  output  1  sticky; at least one match was dropped because the FIFO was full.
REQ-017 busy  output  1  high in RUN and DRAIN.
REQ-018 done  output  1  high while in DONE.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-020 start in any state SHALL clear pos, match_count, overflow and the FIFO, latch plen into plen_q, and enter RUN on the next cycle.
REQ-021 A latched plen greater than NPE SHALL clamp to NPE; plen_q = 0 SHALL never produce a match.
REQ-022 A window is accepted only when in_valid=1 in RUN and start=0; in_valid in other states SHALL be ignored.
REQ-023 An accepted window SHALL match iff match_vec[plen_q-1:0] is all ones and plen_q != 0; bits at or above plen_q are don't-care.
REQ-024 pos SHALL start at 0, increment by 1 per accepted window, and wrap modulo 2^POS_W; a match reports the pos value of its own window.
REQ-025 Each match SHALL increment match_count, saturating at 2^CNT_W-1, whether or not its position is stored.
REQ-026 A match SHALL be pushed if the FIFO is not full or a pop occurs in the same cycle; otherwise the match SHALL be dropped and overflow set.
REQ-027 Into an empty FIFO, a match accepted at edge t SHALL appear on out_valid/out_pos after edge t (next cycle); there is no combinational input-to-output path.
REQ-028 out_pos SHALL hold stable while out_valid=1 and out_ready=0; entries SHALL leave in FIFO order.
REQ-029 An accepted window with in_last=1 SHALL be processed normally, and the FSM SHALL move RUN -> DRAIN.
REQ-030 DRAIN -> DONE SHALL occur on the cycle the FIFO becomes empty; DONE SHALL hold until start or reset.
REQ-031 match_count and overflow SHALL remain readable and unchanged in DRAIN, DONE and IDLE.

Reset
REQ-032 reset SHALL take priority over start and all other inputs.
REQ-033 reset SHALL force state IDLE, pos=0, match_count=0, overflow=0, FIFO empty, out_valid=0, out_pos=0, busy=0, done=0.
REQ-034 reset asserted mid-search SHALL discard all queued results.

Verification
REQ-035 plen=3, windows 0..5 with vec 0b111 at pos 1 and 4, out_ready=1 -> out_pos 1 then 4, each one cycle after its window; match_count=2; done after in_last.
REQ-036 plen=0 with all vec = all ones -> no out_valid, match_count=0, DONE reached.
REQ-037 out_ready=0, six consecutive matches with FIFO_DEPTH=4 -> 4 stored (pos 0..3), overflow=1, match_count=6; then out_ready=1 -> drains 0,1,2,3, then DONE.
REQ-038 FIFO full with out_ready=1 and a simultaneous match -> push accepted, overflow stays 0.
REQ-039 pos at 0xFFFF then matches on two further windows -> reported out_pos 0xFFFF then 0x0000.
REQ-040 reset during RUN with 2 queued entries -> next cycle out_valid=0, match_count=0, busy=0; in_valid ignored until start.

Source files
------------

// File: rtl/match_collector.sv
// -----------------------------------------------------------------------------
// match_collector
//
// Gathers per-window compare vectors from an array of NPE match lanes. It
// decides whether each window is a full pattern match and queues the window
// start position of every match in a small result FIFO. It also keeps a
// saturating count of matches and a sticky flag for matches lost to a full
// FIFO.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   start        one-cycle pulse, begins a new search and latches plen
//   plen         active pattern length (clamped to NPE), sampled on start
//   in_valid     match_vec is valid for the next string window
//   in_last      marks the final window of the string (qualified by in_valid)
//   match_vec    per-lane compare bits, bit i = pattern[i] == string[pos+i]
//   out_valid    out_pos holds a reported match position
//   out_ready    consumer takes out_pos when out_valid && out_ready
//   out_pos      window start position of a full match (FIFO head)
//   match_count  number of full matches in the current search (saturating)
//   overflow     sticky, at least one match position was dropped
//   busy         search in progress (RUN or DRAIN)
//   done         search finished and all results drained
// -----------------------------------------------------------------------------
module match_collector #(
    parameter int NPE        = 8,
    parameter int POS_W      = 16,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(NPE+1)-1:0]   plen,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic [NPE-1:0]             match_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [POS_W-1:0]           out_pos,
    output logic [CNT_W-1:0]           match_count,
    output logic                       overflow,
    output logic                       busy,
    output logic                       done
);

    localparam int PLEN_W = $clog2(NPE + 1);
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [PLEN_W-1:0]   plen_q;
    logic [POS_W-1:0]    pos;
    logic [CNT_W-1:0]    match_count_q;
    logic                overflow_q;

    logic [POS_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]       rd_ptr, wr_ptr;
    logic [AW:0]         fifo_cnt, fifo_cnt_nxt;

    logic                accept, hit, full, push, pop;

    // Lengths above the lane count cannot be honoured; use every lane instead.
    function automatic logic [PLEN_W-1:0] clamp_plen(input logic [PLEN_W-1:0] p);
        if (int'(p) > NPE)
            return PLEN_W'(NPE);
        return p;
    endfunction

    // A window matches when the low p lanes all compare equal; a zero-length
    // pattern never matches.
    function automatic logic pattern_hit(input logic [NPE-1:0]    vec,
                                         input logic [PLEN_W-1:0] p);
        logic [NPE-1:0] mask;
        mask = '0;
        for (int i = 0; i < NPE; i++)
            if (i < int'(p))
                mask[i] = 1'b1;
        return (p != '0) && ((vec & mask) == mask);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    assign accept = (state == RUN) && in_valid && !start;
    assign hit    = accept && pattern_hit(match_vec, plen_q);
    assign full   = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign pop    = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still push.
    assign push   = hit && (!full || pop);

    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        case ({push, pop})
            2'b10:   fifo_cnt_nxt = fifo_cnt + 1'b1;
            2'b01:   fifo_cnt_nxt = fifo_cnt - 1'b1;
            default: fifo_cnt_nxt = fifo_cnt;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     if (accept && in_last) state_nxt = DRAIN;
                DRAIN:   if (fifo_cnt_nxt == '0) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            plen_q        <= '0;
            pos           <= '0;
            match_count_q <= '0;
            overflow_q    <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_cnt      <= '0;
        end else if (start) begin
            state         <= state_nxt;
            plen_q        <= clamp_plen(plen);
            pos           <= '0;
            match_count_q <= '0;
            overflow_q    <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                pos <= pos + 1'b1;
            if (hit)
                match_count_q <= sat_inc(match_count_q);
            if (hit && !push)
                overflow_q <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt_nxt;
        end
    end

    // Result storage carries no reset; out_pos is gated while empty.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= pos;
    end

    assign out_valid   = (fifo_cnt != '0);
    assign out_pos     = out_valid ? fifo_mem[rd_ptr] : '0;
    assign match_count = match_count_q;
    assign overflow    = overflow_q;
    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_match_collector.sv
module tb_match_collector;

    localparam int NPE        = 8;
    localparam int POS_W      = 16;
    localparam int CNT_W      = 16;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [3:0]        plen = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic [NPE-1:0]    match_vec = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [POS_W-1:0]  out_pos;
    logic [CNT_W-1:0]  match_count;
    logic              overflow;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    match_collector #(
        .NPE(NPE), .POS_W(POS_W), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .plen(plen),
        .in_valid(in_valid), .in_last(in_last), .match_vec(match_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
        .match_count(match_count), .overflow(overflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Stimulus tasks begin and end on a falling edge.
    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_search(input logic [3:0] p);
        start = 1'b1;
        plen  = p;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b1; match_vec = '1;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_pos !== 16'h0) begin errors++; $display("FAIL reset_out_pos got %h want 0000", out_pos); end
        checks++; if (match_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", match_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        reset = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || match_count !== 16'd0) begin errors++; $display("FAIL idle_ignores_in_valid busy %0b count %0d want 0 0", busy, match_count); end
        in_valid = 1'b0; match_vec = '0;
    endtask

    task automatic test_basic;
        logic [NPE-1:0] vecs [6];
        vecs[0] = 8'b0000_0011; vecs[1] = 8'b0000_0111; vecs[2] = 8'b1111_1011;
        vecs[3] = 8'b0000_0110; vecs[4] = 8'b1111_0111; vecs[5] = 8'b0000_0101;
        out_ready = 1'b1;
        start_search(4'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b want 1", busy); end
        for (int w = 0; w < 6; w++) begin
            in_valid = 1'b1; match_vec = vecs[w]; in_last = (w == 5);
            step();
            in_valid = 1'b0; in_last = 1'b0;
            if (w == 1 || w == 4) begin
                checks++; if (out_valid !== 1'b1 || out_pos !== 16'(w)) begin errors++; $display("FAIL basic_hit w%0d got valid %0b pos %0d want 1 %0d", w, out_valid, out_pos, w); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_nohit w%0d got valid %0b want 0", w, out_valid); end
            end
        end
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_drain got done %0b busy %0b want 0 1", done, busy); end
        step();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done got done %0b busy %0b want 1 0", done, busy); end
        checks++; if (match_count !== 16'd2) begin errors++; $display("FAIL basic_count got %0d want 2", match_count); end
    endtask

    task automatic test_plen_zero;
        int cyc;
        logic seen_valid;
        out_ready = 1'b1;
        start_search(4'd0);
        seen_valid = 1'b0;
        for (int w = 0; w < 3; w++) begin
            in_valid = 1'b1; match_vec = '1; in_last = (w == 2);
            step();
            if (out_valid) seen_valid = 1'b1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        cyc = 0;
        while (!done && cyc < 10) begin
            if (out_valid) seen_valid = 1'b1;
            step();
            cyc++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL plen0_done timeout got %0b want 1", done); end
        checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL plen0_out_valid got %0b want 0", seen_valid); end
        checks++; if (match_count !== 16'd0) begin errors++; $display("FAIL plen0_count got %0d want 0", match_count); end
    endtask

    task automatic test_clamp;
        out_ready = 1'b1;
        start_search(4'd15);
        in_valid = 1'b1; match_vec = 8'h7F;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clamp_partial got valid %0b want 0", out_valid); end
        match_vec = 8'hFF;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pos !== 16'd1) begin errors++; $display("FAIL clamp_full got valid %0b pos %0d want 1 1", out_valid, out_pos); end
    endtask

    task automatic test_overflow;
        out_ready = 1'b0;
        start_search(4'd1);
        for (int w = 0; w < 6; w++) begin
            in_valid = 1'b1; match_vec = 8'h01; in_last = (w == 5);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        checks++; if (match_count !== 16'd6) begin errors++; $display("FAIL ovf_count got %0d want 6", match_count); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pos !== 16'd0 || busy !== 1'b1) begin errors++; $display("FAIL ovf_hold got valid %0b pos %0d busy %0b want 1 0 1", out_valid, out_pos, busy); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_pos !== 16'(k)) begin errors++; $display("FAIL ovf_drain%0d got valid %0b pos %0d want 1 %0d", k, out_valid, out_pos, k); end
            step();
        end
        checks++; if (out_valid !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL ovf_done got valid %0b done %0b want 0 1", out_valid, done); end
        checks++; if (overflow !== 1'b1 || match_count !== 16'd6) begin errors++; $display("FAIL ovf_sticky got ovf %0b count %0d want 1 6", overflow, match_count); end
    endtask

    task automatic test_full_simul;
        out_ready = 1'b0;
        start_search(4'd1);
        for (int w = 0; w < 4; w++) begin
            in_valid = 1'b1; match_vec = 8'h01;
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow got %0b want 0", overflow); end
        checks++; if (match_count !== 16'd5) begin errors++; $display("FAIL simul_count got %0d want 5", match_count); end
        for (int k = 1; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1 || out_pos !== 16'(k)) begin errors++; $display("FAIL simul_order%0d got valid %0b pos %0d want 1 %0d", k, out_valid, out_pos, k); end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_wrap;
        out_ready = 1'b1;
        start_search(4'd1);
        in_valid = 1'b1; match_vec = 8'h00;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        match_vec = 8'h01;
        step();
        checks++; if (out_valid !== 1'b1 || out_pos !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got valid %0b pos %h want 1 ffff", out_valid, out_pos); end
        in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pos !== 16'h0000) begin errors++; $display("FAIL wrap_0000 got valid %0b pos %h want 1 0000", out_valid, out_pos); end
        checks++; if (match_count !== 16'd2) begin errors++; $display("FAIL wrap_count got %0d want 2", match_count); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        start_search(4'd1);
        for (int w = 0; w < 2; w++) begin
            in_valid = 1'b1; match_vec = 8'h01;
            step();
        end
        checks++; if (out_valid !== 1'b1 || match_count !== 16'd2) begin errors++; $display("FAIL rstmid_pre got valid %0b count %0d want 1 2", out_valid, match_count); end
        reset = 1'b1; start = 1'b1; plen = 4'd1;
        step();
        reset = 1'b0; start = 1'b0;
        checks++; if (out_valid !== 1'b0 || match_count !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_post got valid %0b count %0d busy %0b want 0 0 0", out_valid, match_count, busy); end
        step();
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || match_count !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_ignore got valid %0b count %0d busy %0b want 0 0 0", out_valid, match_count, busy); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_plen_zero();
        test_clamp();
        test_overflow();
        test_full_simul();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
